// File: rtl/buffered_bus_interface_pkg.sv
`default_nettype none
// ============================================================================
// Module  : buffered_bus_interface_pkg
// Brief   : Shared send-FSM state encoding and fill-count width helper for
//           the buffered bus interface and its FIFOs.
// Revision: 1.0 - initial release
// ============================================================================
package buffered_bus_interface_pkg;

    // Per-interface send handshake states
    typedef enum logic [1:0] {
        SEND_IDLE  = 2'd0,
        SEND_START = 2'd1,
        SEND_ACK   = 2'd2,
        SEND_DONE  = 2'd3
    } send_state_t;

    // A fill count must represent 0..depth inclusive, hence one extra bit
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/buffered_bus_interface_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo
// Brief   : Single-clock first-word-fall-through FIFO with fill count.
//           A push on a full FIFO is accepted only when a pop happens in the
//           same cycle; a pop on an empty FIFO is ignored.
// Revision: 1.0 - initial release
// ============================================================================
module sync_fifo
    import buffered_bus_interface_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int CNT_W = cnt_width(DEPTH),
    localparam int PTR_W = $clog2(DEPTH)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CNT_W'(DEPTH));
    assign count     = r_count;
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    // Head is forced to zero while empty so the output is clean after reset
    assign dout = empty ? '0 : r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents need no reset since empty masks the head
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/buffered_bus_interface.sv
`default_nettype none
// ============================================================================
// Module  : buffered_bus_interface
// Brief   : Per-interface receive and fake-send FIFOs between the bus
//           controller and the MITM logic, send handshake sequencing, sticky
//           overflow flags and receive fill level reporting.
// Revision: 1.0 - initial release
// ============================================================================
module buffered_bus_interface
    import buffered_bus_interface_pkg::*;
#(
    parameter int NUM_DATA_BITS = 8,
    parameter int NUM_IFS       = 2,
    parameter int FIFO_DEPTH    = 16,
    localparam int CNT_W        = cnt_width(FIFO_DEPTH)
)(
    input  logic                              sys_clk,
    input  logic                              rst,
    input  logic [NUM_IFS-1:0]                ctrl_recv_ready,
    input  logic [NUM_IFS*NUM_DATA_BITS-1:0]  ctrl_recv_data,
    input  logic [NUM_IFS-1:0]                ctrl_send_ready,
    output logic [NUM_IFS-1:0]                ctrl_send_select,
    output logic [NUM_IFS-1:0]                ctrl_send_start,
    output logic [NUM_IFS*NUM_DATA_BITS-1:0]  ctrl_send_data,
    input  logic [NUM_IFS-1:0]                mitm_send_select,
    output logic [NUM_IFS-1:0]                mitm_recv_valid,
    output logic [NUM_IFS*NUM_DATA_BITS-1:0]  mitm_recv_data,
    input  logic [NUM_IFS-1:0]                mitm_recv_pop,
    input  logic [NUM_IFS-1:0]                mitm_send_push,
    input  logic [NUM_IFS*NUM_DATA_BITS-1:0]  mitm_send_data,
    output logic [NUM_IFS-1:0]                mitm_send_full,
    output logic [NUM_IFS*CNT_W-1:0]          recv_count,
    output logic [2*NUM_IFS-1:0]              overflow,
    input  logic                              overflow_clr
);

    localparam int W = NUM_DATA_BITS;

    logic [2*NUM_IFS-1:0] w_ovf_set;
    logic [2*NUM_IFS-1:0] r_overflow;

    generate
        for (genvar i = 0; i < NUM_IFS; i++) begin : g_if
            logic [W-1:0]     w_rx_dout;
            logic             w_rx_empty;
            logic             w_rx_full;
            logic [CNT_W-1:0] w_rx_count;
            logic [W-1:0]     w_tx_head;
            logic             w_tx_empty;
            logic             w_tx_full;
            logic [CNT_W-1:0] w_tx_count_unused;
            logic             w_tx_pop;
            logic             w_load;
            logic             w_start;
            logic             w_sel_out;
            send_state_t      r_state;
            send_state_t      w_state_nxt;
            logic             r_sel;
            logic [W-1:0]     r_send_data;

            sync_fifo #(
                .WIDTH (W),
                .DEPTH (FIFO_DEPTH)
            ) u_rx_fifo (
                .clk   (sys_clk),
                .rst   (rst),
                .push  (ctrl_recv_ready[i]),
                .pop   (mitm_recv_pop[i]),
                .din   (ctrl_recv_data[i*W +: W]),
                .dout  (w_rx_dout),
                .empty (w_rx_empty),
                .full  (w_rx_full),
                .count (w_rx_count)
            );

            sync_fifo #(
                .WIDTH (W),
                .DEPTH (FIFO_DEPTH)
            ) u_tx_fifo (
                .clk   (sys_clk),
                .rst   (rst),
                .push  (mitm_send_push[i]),
                .pop   (w_tx_pop),
                .din   (mitm_send_data[i*W +: W]),
                .dout  (w_tx_head),
                .empty (w_tx_empty),
                .full  (w_tx_full),
                .count (w_tx_count_unused)
            );

            assign mitm_recv_valid[i]            = ~w_rx_empty;
            assign mitm_recv_data[i*W +: W]      = w_rx_dout;
            assign recv_count[i*CNT_W +: CNT_W]  = w_rx_count;
            assign mitm_send_full[i]             = w_tx_full;

            // A receive on a full FIFO is lost unless a pop frees a slot
            assign w_ovf_set[2*i]   = ctrl_recv_ready[i] & w_rx_full & ~mitm_recv_pop[i];
            // Likewise a push is lost unless the FSM pops in the same cycle
            assign w_ovf_set[2*i+1] = mitm_send_push[i] & w_tx_full & ~w_tx_pop;

            // Select stays asserted until an in-flight word has fully completed
            assign w_sel_out           = r_sel | (r_state != SEND_IDLE);
            assign ctrl_send_select[i] = w_sel_out;
            assign ctrl_send_start[i]  = w_start;
            assign ctrl_send_data[i*W +: W] = r_send_data;

            // Send state, registered select and held send word
            always_ff @(posedge sys_clk) begin
                if (!rst) begin
                    r_state     <= SEND_IDLE;
                    r_sel       <= 1'b0;
                    r_send_data <= '0;
                end else begin
                    r_state <= w_state_nxt;
                    r_sel   <= mitm_send_select[i];
                    if (w_load) begin
                        r_send_data <= w_tx_head;
                    end
                end
            end

            // Send handshake: start strobe, wait for ready low, then ready high
            always_comb begin
                w_state_nxt = r_state;
                w_load      = 1'b0;
                w_tx_pop    = 1'b0;
                w_start     = 1'b0;
                case (r_state)
                    SEND_IDLE: begin
                        if (w_sel_out && !w_tx_empty && ctrl_send_ready[i]) begin
                            w_state_nxt = SEND_START;
                            w_load      = 1'b1;
                        end
                    end
                    SEND_START: begin
                        w_start     = 1'b1;
                        w_tx_pop    = 1'b1;
                        w_state_nxt = SEND_ACK;
                    end
                    SEND_ACK: begin
                        if (!ctrl_send_ready[i]) begin
                            w_state_nxt = SEND_DONE;
                        end
                    end
                    SEND_DONE: begin
                        if (ctrl_send_ready[i]) begin
                            w_state_nxt = SEND_IDLE;
                        end
                    end
                    default: w_state_nxt = SEND_IDLE;
                endcase
            end
        end
    endgenerate

    // Sticky overflow flags; a new event wins over a simultaneous clear
    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            r_overflow <= '0;
        end else begin
            r_overflow <= (overflow_clr ? '0 : r_overflow) | w_ovf_set;
        end
    end

    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_buffered_bus_interface.sv
`default_nettype none
// ============================================================================
// Module  : tb_buffered_bus_interface
// Brief   : Self-checking bench for buffered_bus_interface with a simple
//           controller model and queue-based reference models.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_buffered_bus_interface;

    localparam int W  = 8;
    localparam int N  = 2;
    localparam int D  = 16;
    localparam int CW = 5;

    logic           sys_clk = 1'b0;
    logic           rst;
    logic [N-1:0]   ctrl_recv_ready;
    logic [N*W-1:0] ctrl_recv_data;
    logic [N-1:0]   ctrl_send_ready;
    logic [N-1:0]   ctrl_send_select;
    logic [N-1:0]   ctrl_send_start;
    logic [N*W-1:0] ctrl_send_data;
    logic [N-1:0]   mitm_send_select;
    logic [N-1:0]   mitm_recv_valid;
    logic [N*W-1:0] mitm_recv_data;
    logic [N-1:0]   mitm_recv_pop;
    logic [N-1:0]   mitm_send_push;
    logic [N*W-1:0] mitm_send_data;
    logic [N-1:0]   mitm_send_full;
    logic [N*CW-1:0] recv_count;
    logic [2*N-1:0] overflow;
    logic           overflow_clr;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [W-1:0] strobe_q [N][$];
    logic [W-1:0] rx_model [N][$];
    logic [W-1:0] tx_model [N][$];
    logic [2*N-1:0] m_ovf;
    int dly [N];
    int last_strobe [N];

    buffered_bus_interface #(
        .NUM_DATA_BITS (W),
        .NUM_IFS       (N),
        .FIFO_DEPTH    (D)
    ) dut (
        .sys_clk          (sys_clk),
        .rst              (rst),
        .ctrl_recv_ready  (ctrl_recv_ready),
        .ctrl_recv_data   (ctrl_recv_data),
        .ctrl_send_ready  (ctrl_send_ready),
        .ctrl_send_select (ctrl_send_select),
        .ctrl_send_start  (ctrl_send_start),
        .ctrl_send_data   (ctrl_send_data),
        .mitm_send_select (mitm_send_select),
        .mitm_recv_valid  (mitm_recv_valid),
        .mitm_recv_data   (mitm_recv_data),
        .mitm_recv_pop    (mitm_recv_pop),
        .mitm_send_push   (mitm_send_push),
        .mitm_send_data   (mitm_send_data),
        .mitm_send_full   (mitm_send_full),
        .recv_count       (recv_count),
        .overflow         (overflow),
        .overflow_clr     (overflow_clr)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Controller model: ready drops one cycle after a start strobe and
    // returns four cycles later; every strobe is logged and sanity-checked
    always @(negedge sys_clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst !== 1'b1) begin
                ctrl_send_ready[i] = 1'b1;
                dly[i]             = 0;
                last_strobe[i]     = -1;
            end else if (ctrl_send_start[i] === 1'b1) begin
                n_checks++;
                if (ctrl_send_ready[i] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL strobe_while_not_ready if%0d: ready=%b required 1", i, ctrl_send_ready[i]);
                end
                n_checks++;
                if (last_strobe[i] >= 0 && (cyc - last_strobe[i]) < 3) begin
                    n_fail++;
                    $display("FAIL strobe_spacing if%0d: gap=%0d required >=3", i, cyc - last_strobe[i]);
                end
                last_strobe[i] = cyc;
                strobe_q[i].push_back(ctrl_send_data[i*W +: W]);
                dly[i] = 1;
            end else if (dly[i] > 0) begin
                dly[i]++;
                if (dly[i] == 2) ctrl_send_ready[i] = 1'b0;
                if (dly[i] == 6) begin
                    ctrl_send_ready[i] = 1'b1;
                    dly[i]             = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic clear_strobes();
        for (int i = 0; i < N; i++) strobe_q[i].delete();
    endtask

    task automatic wait_select_low();
        int t = 0;
        while (t < 100 && ctrl_send_select !== '0) begin
            @(negedge sys_clk);
            t++;
        end
        n_checks++;
        if (ctrl_send_select !== '0) begin
            n_fail++;
            $display("FAIL select_release_timeout: select=%b required 00", ctrl_send_select);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) step();
        @(negedge sys_clk);
        n_checks++;
        if ({ctrl_send_select, ctrl_send_start, ctrl_send_data, mitm_recv_valid,
             mitm_recv_data, mitm_send_full, recv_count, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: sel=%b start=%b data=%h valid=%b rdata=%h full=%b cnt=%h ovf=%b required all 0",
                     ctrl_send_select, ctrl_send_start, ctrl_send_data, mitm_recv_valid,
                     mitm_recv_data, mitm_send_full, recv_count, overflow);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_rx_fill();
        for (int k = 0; k < 17; k++) begin
            ctrl_recv_ready[1]   = 1'b1;
            ctrl_recv_data[15:8] = 8'(k);
            step();
        end
        ctrl_recv_ready = '0;
        @(negedge sys_clk);
        n_checks++;
        if (recv_count[9:5] !== 5'd16) begin
            n_fail++;
            $display("FAIL rx_fill_count if1: got %0d required 16", recv_count[9:5]);
        end
        n_checks++;
        if (overflow !== 4'b0100) begin
            n_fail++;
            $display("FAIL rx_fill_overflow: got %b required 0100", overflow);
        end
        n_checks++;
        if (recv_count[4:0] !== 5'd0 || mitm_recv_valid[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rx_fill_if0_untouched: count=%0d valid=%b required 0/0", recv_count[4:0], mitm_recv_valid[0]);
        end
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge sys_clk);
            n_checks++;
            if (mitm_recv_valid[1] !== 1'b1 || mitm_recv_data[15:8] !== 8'(k)) begin
                n_fail++;
                $display("FAIL rx_fill_head[%0d]: valid=%b data=%h required 1/%h", k, mitm_recv_valid[1], mitm_recv_data[15:8], 8'(k));
            end
            mitm_recv_pop[1] = 1'b1;
            step();
            mitm_recv_pop[1] = 1'b0;
        end
        @(negedge sys_clk);
        n_checks++;
        if (mitm_recv_valid[1] !== 1'b0 || recv_count[9:5] !== 5'd0) begin
            n_fail++;
            $display("FAIL rx_fill_drained: valid=%b count=%0d required 0/0", mitm_recv_valid[1], recv_count[9:5]);
        end
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
    endtask

    task automatic test_rx_full_pop();
        for (int k = 0; k < 16; k++) begin
            ctrl_recv_ready[0]  = 1'b1;
            ctrl_recv_data[7:0] = 8'(8'h30 + k);
            step();
        end
        ctrl_recv_ready[0]  = 1'b1;
        ctrl_recv_data[7:0] = 8'hAA;
        mitm_recv_pop[0]    = 1'b1;
        step();
        ctrl_recv_ready = '0;
        mitm_recv_pop   = '0;
        @(negedge sys_clk);
        n_checks++;
        if (recv_count[4:0] !== 5'd16 || overflow !== 4'b0000) begin
            n_fail++;
            $display("FAIL rx_full_pop: count=%0d ovf=%b required 16/0000", recv_count[4:0], overflow);
        end
        for (int k = 0; k < 16; k++) begin
            logic [W-1:0] exp_w;
            exp_w = (k == 15) ? 8'hAA : 8'(8'h31 + k);
            if (k > 0) @(negedge sys_clk);
            n_checks++;
            if (mitm_recv_data[7:0] !== exp_w) begin
                n_fail++;
                $display("FAIL rx_full_pop_order[%0d]: got %h required %h", k, mitm_recv_data[7:0], exp_w);
            end
            mitm_recv_pop[0] = 1'b1;
            step();
            mitm_recv_pop[0] = 1'b0;
        end
    endtask

    task automatic test_tx_seq();
        int t = 0;
        logic [W-1:0] exp_w [3];
        exp_w = '{8'h11, 8'h22, 8'h33};
        clear_strobes();
        for (int k = 0; k < 3; k++) begin
            mitm_send_push[0]   = 1'b1;
            mitm_send_data[7:0] = exp_w[k];
            step();
        end
        mitm_send_push      = '0;
        mitm_send_select[0] = 1'b1;
        while (t < 200 && strobe_q[0].size() < 3) begin
            @(negedge sys_clk);
            t++;
        end
        repeat (10) @(negedge sys_clk);
        n_checks++;
        if (strobe_q[0].size() != 3 || strobe_q[1].size() != 0) begin
            n_fail++;
            $display("FAIL tx_seq_count: if0=%0d if1=%0d required 3/0", strobe_q[0].size(), strobe_q[1].size());
        end
        for (int k = 0; k < 3 && k < strobe_q[0].size(); k++) begin
            n_checks++;
            if (strobe_q[0][k] !== exp_w[k]) begin
                n_fail++;
                $display("FAIL tx_seq_data[%0d]: got %h required %h", k, strobe_q[0][k], exp_w[k]);
            end
        end
        mitm_send_select[0] = 1'b0;
        wait_select_low();
    endtask

    task automatic test_deselect();
        int t = 0;
        clear_strobes();
        for (int k = 0; k < 3; k++) begin
            mitm_send_push[0]   = 1'b1;
            mitm_send_data[7:0] = 8'(8'h44 + 8'h11 * k);
            step();
        end
        mitm_send_push      = '0;
        mitm_send_select[0] = 1'b1;
        while (t < 100 && ctrl_send_start[0] !== 1'b1) begin
            @(negedge sys_clk);
            t++;
        end
        n_checks++;
        if (ctrl_send_start[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL deselect_first_start: start=%b required 1", ctrl_send_start[0]);
        end
        step();
        mitm_send_select[0] = 1'b0;
        repeat (40) @(negedge sys_clk);
        n_checks++;
        if (strobe_q[0].size() != 1 || ctrl_send_select[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL deselect_stop: strobes=%0d sel=%b required 1/0", strobe_q[0].size(), ctrl_send_select[0]);
        end
        mitm_send_select[0] = 1'b1;
        t = 0;
        while (t < 200 && strobe_q[0].size() < 3) begin
            @(negedge sys_clk);
            t++;
        end
        repeat (10) @(negedge sys_clk);
        n_checks++;
        if (strobe_q[0].size() != 3) begin
            n_fail++;
            $display("FAIL deselect_remaining: strobes=%0d required 3", strobe_q[0].size());
        end else begin
            n_checks++;
            if (strobe_q[0][0] !== 8'h44 || strobe_q[0][1] !== 8'h55 || strobe_q[0][2] !== 8'h66) begin
                n_fail++;
                $display("FAIL deselect_data: got %h %h %h required 44 55 66", strobe_q[0][0], strobe_q[0][1], strobe_q[0][2]);
            end
        end
        mitm_send_select[0] = 1'b0;
        wait_select_low();
    endtask

    task automatic test_ovf_clr();
        int t = 0;
        clear_strobes();
        for (int k = 0; k < 16; k++) begin
            mitm_send_push[0]   = 1'b1;
            mitm_send_data[7:0] = 8'(8'h80 + k);
            step();
        end
        mitm_send_push = '0;
        @(negedge sys_clk);
        n_checks++;
        if (mitm_send_full !== 2'b01 || overflow !== 4'b0000) begin
            n_fail++;
            $display("FAIL tx_full_flag: full=%b ovf=%b required 01/0000", mitm_send_full, overflow);
        end
        step();
        mitm_send_push[0]   = 1'b1;
        mitm_send_data[7:0] = 8'hEE;
        overflow_clr        = 1'b1;
        step();
        mitm_send_push = '0;
        overflow_clr   = 1'b0;
        @(negedge sys_clk);
        n_checks++;
        if (overflow !== 4'b0010) begin
            n_fail++;
            $display("FAIL ovf_set_beats_clear: got %b required 0010", overflow);
        end
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        @(negedge sys_clk);
        n_checks++;
        if (overflow !== 4'b0000) begin
            n_fail++;
            $display("FAIL ovf_clear: got %b required 0000", overflow);
        end
        mitm_send_select[0] = 1'b1;
        while (t < 400 && strobe_q[0].size() < 16) begin
            @(negedge sys_clk);
            t++;
        end
        repeat (10) @(negedge sys_clk);
        n_checks++;
        if (strobe_q[0].size() != 16) begin
            n_fail++;
            $display("FAIL tx_drain_count: got %0d required 16", strobe_q[0].size());
        end
        for (int k = 0; k < 16 && k < strobe_q[0].size(); k++) begin
            n_checks++;
            if (strobe_q[0][k] !== 8'(8'h80 + k)) begin
                n_fail++;
                $display("FAIL tx_drain_data[%0d]: got %h required %h", k, strobe_q[0][k], 8'(8'h80 + k));
            end
        end
        mitm_send_select[0] = 1'b0;
        wait_select_low();
    endtask

    task automatic test_random_rx();
        logic [2*N-1:0] set_v;
        logic           pe;
        logic           was_full;
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        m_ovf = '0;
        for (int i = 0; i < N; i++) rx_model[i].delete();
        for (int c = 0; c < 400; c++) begin
            @(negedge sys_clk);
            for (int i = 0; i < N; i++) begin
                n_checks++;
                if (mitm_recv_valid[i] !== (rx_model[i].size() != 0) ||
                    recv_count[i*CW +: CW] !== CW'(rx_model[i].size())) begin
                    n_fail++;
                    $display("FAIL rand_rx_state if%0d c%0d: valid=%b count=%0d required %0d entries",
                             i, c, mitm_recv_valid[i], recv_count[i*CW +: CW], rx_model[i].size());
                end
                if (rx_model[i].size() != 0) begin
                    n_checks++;
                    if (mitm_recv_data[i*W +: W] !== rx_model[i][0]) begin
                        n_fail++;
                        $display("FAIL rand_rx_head if%0d c%0d: got %h required %h", i, c, mitm_recv_data[i*W +: W], rx_model[i][0]);
                    end
                end
            end
            n_checks++;
            if (overflow !== m_ovf) begin
                n_fail++;
                $display("FAIL rand_rx_overflow c%0d: got %b required %b", c, overflow, m_ovf);
            end
            set_v = '0;
            for (int i = 0; i < N; i++) begin
                ctrl_recv_ready[i]       = ($urandom_range(0, 99) < ((c < 200) ? 70 : 30));
                mitm_recv_pop[i]         = ($urandom_range(0, 99) < ((c < 200) ? 30 : 70));
                ctrl_recv_data[i*W +: W] = 8'($urandom);
                was_full = (rx_model[i].size() == D);
                pe       = mitm_recv_pop[i] && (rx_model[i].size() != 0);
                if (pe) void'(rx_model[i].pop_front());
                if (ctrl_recv_ready[i]) begin
                    if (was_full && !pe) set_v[2*i] = 1'b1;
                    else rx_model[i].push_back(ctrl_recv_data[i*W +: W]);
                end
            end
            overflow_clr = ($urandom_range(0, 19) == 0);
            m_ovf = (overflow_clr ? '0 : m_ovf) | set_v;
        end
        step();
        ctrl_recv_ready = '0;
        overflow_clr    = 1'b1;
        mitm_recv_pop   = '1;
        repeat (20) step();
        mitm_recv_pop = '0;
        overflow_clr  = 1'b0;
    endtask

    task automatic test_random_tx();
        int n_w [N];
        int t;
        for (int r = 0; r < 3; r++) begin
            wait_select_low();
            clear_strobes();
            for (int i = 0; i < N; i++) begin
                tx_model[i].delete();
                n_w[i] = $urandom_range(1, 10);
            end
            for (int k = 0; k < 10; k++) begin
                for (int i = 0; i < N; i++) begin
                    mitm_send_push[i]        = (k < n_w[i]);
                    mitm_send_data[i*W +: W] = 8'($urandom);
                    if (k < n_w[i]) tx_model[i].push_back(mitm_send_data[i*W +: W]);
                end
                step();
            end
            mitm_send_push   = '0;
            mitm_send_select = '1;
            t = 0;
            while (t < 300 && (strobe_q[0].size() < tx_model[0].size() ||
                               strobe_q[1].size() < tx_model[1].size())) begin
                @(negedge sys_clk);
                t++;
            end
            repeat (10) @(negedge sys_clk);
            for (int i = 0; i < N; i++) begin
                n_checks++;
                if (strobe_q[i].size() != tx_model[i].size()) begin
                    n_fail++;
                    $display("FAIL rand_tx_count r%0d if%0d: got %0d required %0d", r, i, strobe_q[i].size(), tx_model[i].size());
                end else begin
                    for (int k = 0; k < tx_model[i].size(); k++) begin
                        n_checks++;
                        if (strobe_q[i][k] !== tx_model[i][k]) begin
                            n_fail++;
                            $display("FAIL rand_tx_data r%0d if%0d[%0d]: got %h required %h", r, i, k, strobe_q[i][k], tx_model[i][k]);
                        end
                    end
                end
            end
            mitm_send_select = '0;
        end
        wait_select_low();
    endtask

    task automatic test_reset_mid_send();
        int t = 0;
        clear_strobes();
        for (int k = 0; k < 5; k++) begin
            mitm_send_push[0]    = 1'b1;
            mitm_send_data[7:0]  = 8'(8'hC0 + k);
            ctrl_recv_ready[1]   = (k < 3);
            ctrl_recv_data[15:8] = 8'(k);
            step();
        end
        mitm_send_push      = '0;
        ctrl_recv_ready     = '0;
        mitm_send_select[0] = 1'b1;
        while (t < 100 && ctrl_send_start[0] !== 1'b1) begin
            @(negedge sys_clk);
            t++;
        end
        n_checks++;
        if (ctrl_send_start[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_send_start: start=%b required 1", ctrl_send_start[0]);
        end
        step();
        rst = 1'b0;
        step();
        @(negedge sys_clk);
        n_checks++;
        if ({ctrl_send_select, ctrl_send_start, ctrl_send_data, mitm_recv_valid,
             mitm_recv_data, mitm_send_full, recv_count, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_send_outputs: sel=%b start=%b data=%h valid=%b rdata=%h full=%b cnt=%h ovf=%b required all 0",
                     ctrl_send_select, ctrl_send_start, ctrl_send_data, mitm_recv_valid,
                     mitm_recv_data, mitm_send_full, recv_count, overflow);
        end
        rst = 1'b1;
        step();
        clear_strobes();
        repeat (30) @(negedge sys_clk);
        n_checks++;
        if (strobe_q[0].size() != 0 || mitm_recv_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_discard: strobes=%0d valid=%b required 0/00", strobe_q[0].size(), mitm_recv_valid);
        end
        mitm_send_select = '0;
    endtask

    initial begin
        rst              = 1'b0;
        ctrl_recv_ready  = '0;
        ctrl_recv_data   = '0;
        mitm_send_select = '0;
        mitm_recv_pop    = '0;
        mitm_send_push   = '0;
        mitm_send_data   = '0;
        overflow_clr     = 1'b0;
        test_reset();
        test_rx_fill();
        test_rx_full_pop();
        test_tx_seq();
        test_deselect();
        test_ovf_clr();
        test_random_rx();
        test_random_tx();
        test_reset_mid_send();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
